// File: rtl/mips_multicycle_control.sv
// rtl/mips_multicycle_control.sv - multicycle MIPS control FSM driving datapath selects, enables and ALU code
module mips_multicycle_control (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] Op,
    input  logic [5:0] Funct,
    input  logic       Zero,
    output logic       PCEn,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSource,
    output logic [3:0] ALUoperation,
    output logic       InstrDone,
    output logic       IllegalOp,
    output logic [3:0] State
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1000;

    state_t     state;
    state_t     next_state;
    logic       is_load;
    logic       pcwrite;
    logic       branch;
    logic       funct_ok;
    logic [3:0] funct_alu;

    // Load/store choice is captured in DECODE so MEMADR does not depend on Op later.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_FETCH;
            is_load <= 1'b0;
        end else begin
            state <= next_state;
            if (state == S_DECODE) begin
                is_load <= (Op == OP_LW);
            end
        end
    end

    always_comb begin
        funct_ok  = 1'b1;
        funct_alu = ALU_AND;
        case (Funct)
            6'h20:   funct_alu = ALU_ADD;
            6'h22:   funct_alu = ALU_SUB;
            6'h24:   funct_alu = ALU_AND;
            6'h25:   funct_alu = ALU_OR;
            6'h2A:   funct_alu = ALU_SLT;
            6'h27:   funct_alu = ALU_NOR;
            default: funct_ok  = 1'b0;
        endcase
    end

    always_comb begin
        next_state   = S_FETCH;
        pcwrite      = 1'b0;
        branch       = 1'b0;
        IorD         = 1'b0;
        MemRead      = 1'b0;
        MemWrite     = 1'b0;
        IRWrite      = 1'b0;
        RegDst       = 1'b0;
        MemtoReg     = 1'b0;
        RegWrite     = 1'b0;
        ALUSrcA      = 1'b0;
        ALUSrcB      = 2'b00;
        PCSource     = 2'b00;
        ALUoperation = ALU_AND;
        InstrDone    = 1'b0;
        IllegalOp    = 1'b0;
        case (state)
            S_FETCH: begin
                MemRead      = 1'b1;
                IRWrite      = 1'b1;
                ALUSrcB      = 2'b01;
                ALUoperation = ALU_ADD;
                pcwrite      = 1'b1;
                next_state   = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcB      = 2'b11;
                ALUoperation = ALU_ADD;
                case (Op)
                    OP_LW, OP_SW: next_state = S_MEMADR;
                    OP_RTYPE:     next_state = funct_ok ? S_EXEC : S_FETCH;
                    OP_BEQ:       next_state = S_BRANCH;
                    OP_J:         next_state = S_JUMP;
                    OP_ADDI:      next_state = S_ADDIEX;
                    default:      next_state = S_FETCH;
                endcase
                if (next_state == S_FETCH) begin
                    IllegalOp = 1'b1;
                    InstrDone = 1'b1;
                end
            end
            S_MEMADR: begin
                ALUSrcA      = 1'b1;
                ALUSrcB      = 2'b10;
                ALUoperation = ALU_ADD;
                next_state   = is_load ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                MemRead    = 1'b1;
                IorD       = 1'b1;
                next_state = S_MEMWB;
            end
            S_MEMWB: begin
                RegWrite  = 1'b1;
                MemtoReg  = 1'b1;
                InstrDone = 1'b1;
            end
            S_MEMWR: begin
                MemWrite  = 1'b1;
                IorD      = 1'b1;
                InstrDone = 1'b1;
            end
            S_EXEC: begin
                ALUSrcA      = 1'b1;
                ALUoperation = funct_alu;
                next_state   = S_ALUWB;
            end
            S_ALUWB: begin
                RegDst    = 1'b1;
                RegWrite  = 1'b1;
                InstrDone = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA      = 1'b1;
                ALUoperation = ALU_SUB;
                PCSource     = 2'b01;
                branch       = 1'b1;
                InstrDone    = 1'b1;
            end
            S_JUMP: begin
                PCSource  = 2'b10;
                pcwrite   = 1'b1;
                InstrDone = 1'b1;
            end
            S_ADDIEX: begin
                ALUSrcA      = 1'b1;
                ALUSrcB      = 2'b10;
                ALUoperation = ALU_ADD;
                next_state   = S_ADDIWB;
            end
            S_ADDIWB: begin
                RegWrite  = 1'b1;
                InstrDone = 1'b1;
            end
            default: next_state = S_FETCH;
        endcase
        PCEn = pcwrite | (branch & Zero);
        // Reset holds the state at FETCH, so FETCH strobes must be masked explicitly.
        if (reset) begin
            PCEn         = 1'b0;
            IorD         = 1'b0;
            MemRead      = 1'b0;
            MemWrite     = 1'b0;
            IRWrite      = 1'b0;
            RegDst       = 1'b0;
            MemtoReg     = 1'b0;
            RegWrite     = 1'b0;
            ALUSrcA      = 1'b0;
            ALUSrcB      = 2'b00;
            PCSource     = 2'b00;
            ALUoperation = ALU_AND;
            InstrDone    = 1'b0;
            IllegalOp    = 1'b0;
        end
    end

    assign State = state;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// tb/tb_mips_multicycle_control.sv - scoreboard bench for the multicycle control FSM
module tb_mips_multicycle_control;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] Op;
    logic [5:0] Funct;
    logic       Zero;
    logic       PCEn, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, PCSource;
    logic [3:0] ALUoperation, State;
    logic       InstrDone, IllegalOp;

    mips_multicycle_control dut (
        .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Zero(Zero),
        .PCEn(PCEn), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
        .ALUoperation(ALUoperation), .InstrDone(InstrDone), .IllegalOp(IllegalOp),
        .State(State)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] st;
        logic       pcen, iord, memread, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
        logic [1:0] alusrcb, pcsource;
        logic [3:0] aluop;
        logic       done, illegal;
    } rec_t;

    rec_t       exp_q[$];
    rec_t       e, act;
    int         total = 0;
    int         bad = 0;
    event       sample_now;
    bit   [3:0] alu_map[bit [5:0]];
    int         plan_st[0:5];

    // Instruction class -> sequence of visited states.
    function automatic int plan(input logic [5:0] op, input logic [5:0] f);
        plan_st[0] = 0;
        plan_st[1] = 1;
        case (op)
            6'h23: begin plan_st[2] = 2; plan_st[3] = 3; plan_st[4] = 4; return 5; end
            6'h2B: begin plan_st[2] = 2; plan_st[3] = 5; return 4; end
            6'h00: begin
                if (alu_map.exists(f)) begin plan_st[2] = 6; plan_st[3] = 7; return 4; end
                return 2;
            end
            6'h04: begin plan_st[2] = 8; return 3; end
            6'h02: begin plan_st[2] = 9; return 3; end
            6'h08: begin plan_st[2] = 10; plan_st[3] = 11; return 4; end
            default: return 2;
        endcase
    endfunction

    function automatic rec_t exp_rec(input int s, input logic [5:0] f, input logic z, input bit ill);
        rec_t r = '0;
        r.st = s[3:0];
        case (s)
            0:  begin r.memread = 1; r.irwrite = 1; r.alusrcb = 2'b01; r.aluop = 4'b0010; r.pcen = 1; end
            1:  begin r.alusrcb = 2'b11; r.aluop = 4'b0010; r.illegal = ill; r.done = ill; end
            2:  begin r.alusrca = 1; r.alusrcb = 2'b10; r.aluop = 4'b0010; end
            3:  begin r.memread = 1; r.iord = 1; end
            4:  begin r.regwrite = 1; r.memtoreg = 1; r.done = 1; end
            5:  begin r.memwrite = 1; r.iord = 1; r.done = 1; end
            6:  begin r.alusrca = 1; r.aluop = alu_map[f]; end
            7:  begin r.regdst = 1; r.regwrite = 1; r.done = 1; end
            8:  begin r.alusrca = 1; r.aluop = 4'b0110; r.pcsource = 2'b01; r.pcen = z; r.done = 1; end
            9:  begin r.pcsource = 2'b10; r.pcen = 1; r.done = 1; end
            10: begin r.alusrca = 1; r.alusrcb = 2'b10; r.aluop = 4'b0010; end
            11: begin r.regwrite = 1; r.done = 1; end
            default: r = '0;
        endcase
        return r;
    endfunction

    // zmode: 0/1 force Zero, 2 random; abort_memrd: reset pulse during MEMRD.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] f, input int zmode, input bit abort_memrd);
        int n;
        int s;
        logic z;
        n = plan(op, f);
        for (int i = 0; i < n; i++) begin
            s = plan_st[i];
            z = (zmode == 2) ? 1'($urandom) : zmode[0];
            Zero = z;
            if (s == 1 || s == 6) begin
                Op = op;
                Funct = f;
            end else begin
                Op = 6'($urandom);
                Funct = 6'($urandom);
            end
            exp_q.push_back(exp_rec(s, f, z, (s == 1) && (n == 2)));
            if (abort_memrd && s == 3) begin
                @(negedge clk);
                #1;
                reset = 1'b1;
                #1;
                exp_q.push_back('0);
                ->sample_now;
                repeat (3) begin
                    @(posedge clk);
                    #1;
                    exp_q.push_back('0);
                end
                @(posedge clk);
                #1;
                reset = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
    endtask

    always begin
        @(negedge clk or sample_now);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            act = {State, PCEn, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
                   ALUSrcA, ALUSrcB, PCSource, ALUoperation, InstrDone, IllegalOp};
            total++;
            if (act !== e) begin
                bad++;
                $display("FAIL outputs exp_state=%0d got=%h exp=%h", e.st, act, e);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog timeout");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "timeout");
    end

    initial begin
        logic [5:0] fl[6];
        logic [5:0] ops[6];
        logic [5:0] rop, rf;
        alu_map[6'h20] = 4'b0010;
        alu_map[6'h22] = 4'b0110;
        alu_map[6'h24] = 4'b0000;
        alu_map[6'h25] = 4'b0001;
        alu_map[6'h2A] = 4'b0111;
        alu_map[6'h27] = 4'b1000;
        fl = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h27};
        ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08};
        reset = 1'b1;
        Op = 6'h00;
        Funct = 6'h00;
        Zero = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
            exp_q.push_back('0);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;

        run_instr(6'h23, 6'h00, 2, 0);
        for (int i = 0; i < 6; i++) run_instr(6'h00, fl[i], 2, 0);
        run_instr(6'h04, 6'h00, 1, 0);
        run_instr(6'h04, 6'h00, 0, 0);
        run_instr(6'h2B, 6'h00, 2, 0);
        run_instr(6'h02, 6'h00, 2, 0);
        run_instr(6'h08, 6'h00, 2, 0);
        run_instr(6'h3F, 6'h00, 2, 0);
        run_instr(6'h00, 6'h03, 2, 0);
        run_instr(6'h23, 6'h00, 2, 1);
        run_instr(6'h2B, 6'h00, 2, 0);

        for (int k = 0; k < 250; k++) begin
            if ($urandom_range(0, 9) < 8) rop = ops[$urandom_range(0, 5)];
            else rop = 6'($urandom);
            if ($urandom_range(0, 9) < 8) rf = fl[$urandom_range(0, 5)];
            else rf = 6'($urandom);
            run_instr(rop, rf, 2, 0);
        end

        @(negedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL queue_drain got=%0d exp=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_control.md
# mips_multicycle_control

Multicycle control unit for the MIPS datapath. It sequences one instruction at a time through fetch, decode, execute, memory and writeback states. Each cycle it drives the datapath mux selects and write enables, plus the 4-bit ALUoperation code for the shared ALU. It supports add, sub, and, or, slt, nor (R-type), addi, lw, sw, beq and j. It sits between the instruction register's Op/Funct fields and the datapath.

## Interface
- Parameters: none. The ISA subset and encodings are fixed.
- clk  in  1  system clock; rising edge.
- reset  in  1  asynchronous, active-high.
- Op  in  6  instruction[31:26], stable from DECODE onward.
- Funct  in  6  instruction[5:0].
- Zero  in  1  ALU zero flag.
- PCEn  out  1  PC write enable. PCEn = PCWrite | (Branch & Zero).
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
- MemRead, MemWrite  out  1 each  memory strobes.
- IRWrite  out  1  instruction register load.
- RegDst  out  1  destination register select: 0 = rt, 1 = rd.
- MemtoReg  out  1  write-data select: 0 = ALUOut, 1 = MDR.
- RegWrite  out  1  register file write enable.
- ALUSrcA  out  1  ALU A select: 0 = PC, 1 = A.
- ALUSrcB  out  2  ALU B select: 00 = B, 01 = 4, 10 = signext, 11 = signext<<2.
- PCSource  out  2  next-PC select: 00 = ALU, 01 = ALUOut, 10 = jump target.
- ALUoperation  out  4  ALU code: and 0000, or 0001, add 0010, sub 0110, slt 0111, nor 1000.
- InstrDone  out  1  one-cycle pulse in the last state of each instruction.
- IllegalOp  out  1  one-cycle pulse in DECODE when the op or funct is unsupported.
- State  out  4  current state, for debug.

## Operation
- Moore FSM with a 4-bit state register. All outputs are combinational from the state, except three:
  - ALUoperation in EXEC is decoded from Funct.
  - PCEn in BRANCH equals Zero.
  - IllegalOp in DECODE is decoded from Op/Funct.
- Any output not listed for a state is 0, including ALUoperation = 0000.
- Opcodes: R-type 0x00, lw 0x23, sw 0x2B, beq 0x04, j 0x02, addi 0x08.
- Funct codes: add 0x20, sub 0x22, and 0x24, or 0x25, nor 0x27, slt 0x2A.
- States, with their outputs and next state:
  - FETCH (0): MemRead, IRWrite, ALUSrcB=01, ALUoperation=add, PCEn. Next: DECODE.
  - DECODE (1): ALUSrcB=11, ALUoperation=add. Next by Op:
    - lw/sw → MEMADR.
    - R-type with a supported funct → EXEC.
    - beq → BRANCH.
    - j → JUMP.
    - addi → ADDIEX.
    - anything else → FETCH, with IllegalOp=1 and InstrDone=1.
  - MEMADR (2): ALUSrcA=1, ALUSrcB=10, add. Next: MEMRD if lw, MEMWR if sw.
  - MEMRD (3): MemRead, IorD. Next: MEMWB.
  - MEMWB (4): RegWrite, MemtoReg, RegDst=0, InstrDone. Next: FETCH.
  - MEMWR (5): MemWrite, IorD, InstrDone. Next: FETCH.
  - EXEC (6): ALUSrcA=1, ALUSrcB=00, ALUoperation=decode(Funct). Next: ALUWB.
  - ALUWB (7): RegDst=1, RegWrite, InstrDone. Next: FETCH.
  - BRANCH (8): ALUSrcA=1, ALUSrcB=00, sub, PCSource=01, PCEn=Zero, InstrDone. Next: FETCH.
  - JUMP (9): PCSource=10, PCEn=1, InstrDone. Next: FETCH.
  - ADDIEX (10): ALUSrcA=1, ALUSrcB=10, add. Next: ADDIWB.
  - ADDIWB (11): RegDst=0, RegWrite, InstrDone. Next: FETCH.
- Unused state encodings 12–15 drive all outputs to 0 and go to FETCH on the next edge.
- Op/Funct are sampled only in DECODE and EXEC. Changes in other states have no effect.

## Timing
- Reset:
  - Asserting reset forces State=FETCH immediately.
  - While reset is high, every output is forced to 0, including PCEn, IRWrite and MemRead.
  - On the first rising edge after deassertion, State is FETCH with FETCH outputs active for that cycle.
- Reset mid-instruction aborts immediately. No write enable is asserted after reset rises.
- Cycles per instruction, FETCH to FETCH:
  - lw 5.
  - sw, R-type and addi 4.
  - beq and j 3.
  - illegal op 2.
- BRANCH: PCEn follows Zero combinationally within the same cycle. It is only valid while State=BRANCH.
- At most one of MemRead, MemWrite and RegWrite is asserted in any state.

## Test plan
- Reset:
  - Stimulus: hold reset 3 cycles mid-MEMRD, then release.
  - Required: all outputs 0 while reset is high; State=0 asynchronously; FETCH outputs with PCEn=1 one edge after release.
- lw:
  - Stimulus: Op=0x23.
  - Required: states 0,1,2,3,4,0; MEMRD has MemRead=1 and IorD=1; MEMWB has RegWrite=1 and MemtoReg=1; InstrDone pulses once, in state 4.
- R-type:
  - Stimulus: Op=0x00 with each funct 0x20/0x22/0x24/0x25/0x2A/0x27.
  - Required: ALUoperation in EXEC is 0010/0110/0000/0001/0111/1000 respectively; ALUWB has RegDst=1 and RegWrite=1.
- beq:
  - Stimulus: Op=0x04 with Zero=1, then repeat with Zero=0.
  - Required: BRANCH has ALUoperation=0110 and PCSource=01; PCEn=1 for Zero=1 and PCEn=0 for Zero=0; 3 cycles each.
- sw, j and addi:
  - sw (0x2B): states 0,1,2,5; MemWrite only in 5.
  - j (0x02): PCSource=10 and PCEn=1 in state 9.
  - addi (0x08): states 0,1,10,11 with RegDst=0.
- Illegal:
  - Stimulus: Op=0x3F, then Op=0x00 with Funct=0x03.
  - Required: IllegalOp=1 for exactly one DECODE cycle; return to FETCH; no RegWrite, MemWrite or PCEn outside FETCH.
